// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common with the receiver) and oversampling ratio.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity, stop period.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            txstart,
    input  logic            stick,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            txbusy,
    output logic            txdone
);

    localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = $clog2(DBIT) + 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    state_t          r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
`endif

    // tx/txbusy are loaded with the value for the state being entered, so they never glitch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
            tx      <= 1'b1;
            txbusy  <= 1'b0;
            txdone  <= 1'b0;
        end else begin
            txdone <= 1'b0;
            case (r_state)
                IDLE: begin
                    tx     <= 1'b1;
                    txbusy <= 1'b0;
                    if (txstart) begin
                        r_b     <= din;
                        r_s     <= '0;
                        r_state <= START;
                        tx      <= 1'b0;
                        txbusy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^din;
`endif
                    end
                end
                START: begin
                    if (stick) begin
                        if (r_s == S_BIT_LAST) begin
                            r_s     <= '0;
                            r_n     <= '0;
                            r_state <= DATA;
                            tx      <= r_b[0];
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (stick) begin
                        if (r_s == S_BIT_LAST) begin
                            r_s <= '0;
                            r_b <= r_b >> 1;
                            if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                                r_state <= PARITY;
                                tx      <= r_par;
`else
                                r_state <= STOP;
                                tx      <= 1'b1;
`endif
                            end else begin
                                r_n <= r_n + NW'(1);
                                tx  <= r_b[1];
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (stick) begin
                        if (r_s == S_BIT_LAST) begin
                            r_s     <= '0;
                            r_state <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (stick) begin
                        if (r_s == S_STOP_LAST) begin
                            r_s     <= '0;
                            r_state <= IDLE;
                            tx      <= 1'b1;
                            txbusy  <= 1'b0;
                            txdone  <= 1'b1;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    tx      <= 1'b1;
                    txbusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter (DBIT=8, SB_TICK=16); honours UART_TX_PARITY_EN if defined.
module tb_uart_transmitter;

    logic       clk;
    logic       reset_n;
    logic       txstart;
    logic       stick;
    logic [7:0] din;
    logic       tx;
    logic       txbusy;
    logic       txdone;

    int checks = 0;
    int errors = 0;

    int stick_div = 1;
    int stick_cnt = 0;

`ifdef UART_TX_PARITY_EN
    localparam int NB      = 11;
    localparam int PAR_ADD = 16;
`else
    localparam int NB      = 10;
    localparam int PAR_ADD = 0;
`endif

    logic rec_tx [0:2047];
    int   rec_len;
    int   busy_cnt;
    int   done_idx;

    typedef struct {
        logic [7:0] din;
        int         div;
        logic [9:0] frame;    // [0]=start, [8:1]=data LSB first, [9]=stop
        logic       par;
        int         lat;      // clk from txstart to txdone, or -1 when not checked
    } vec_t;

    vec_t vecs [0:5];

    uart_transmitter #(.DBIT(8), .SB_TICK(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .txstart (txstart),
        .stick   (stick),
        .din     (din),
        .tx      (tx),
        .txbusy  (txbusy),
        .txdone  (txdone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // one-clk stick every stick_div clocks
    initial begin
        stick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            stick_cnt = (stick_cnt + 1) % stick_div;
            stick     = (stick_cnt == 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk);
        #1;
        din     = d;
        txstart = 1'b1;
        @(posedge clk);
        #1;
        txstart = 1'b0;
        din     = ~d;
    endtask

    task automatic capture(input int inject_at, input logic [7:0] inj_din);
        rec_len  = 0;
        busy_cnt = 0;
        done_idx = -1;
        for (int j = 0; j < 2000; j++) begin
            @(negedge clk);
            rec_tx[j] = tx;
            if (txbusy) busy_cnt++;
            if (j == inject_at) begin
                txstart = 1'b1;
                din     = inj_din;
            end else if (j == inject_at + 1) begin
                txstart = 1'b0;
            end
            rec_len = j + 1;
            if (txdone) begin
                done_idx = j;
                break;
            end
        end
        check("txdone_timeout", (done_idx >= 0) ? 1 : 0, 1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input int div,
                               input logic [9:0] frame, input logic par, input int lat);
        int         p;
        int         idx;
        int         exp_bit;
        int         act_bit;
        logic [7:0] word;
        p    = 16 * div;
        word = '0;
        for (int k = 0; k < NB; k++) begin
            idx = k * p + p / 2;
            if (k == NB - 1)     exp_bit = 1;
            else if (k == 9)     exp_bit = int'(par);
            else                 exp_bit = int'(frame[k]);
            act_bit = (idx < rec_len) ? int'(rec_tx[idx]) : -1;
            check($sformatf("%s_bit%0d", tag, k), act_bit, exp_bit);
        end
        for (int i = 0; i < 8; i++) begin
            idx = (i + 1) * p + p / 2;
            word[i] = (idx < rec_len) ? rec_tx[idx] : 1'b0;
        end
        check($sformatf("%s_word", tag), int'(word), int'(d));
        if (lat > 0) begin
            check($sformatf("%s_txdone_latency", tag), done_idx + 1, lat + PAR_ADD);
            check($sformatf("%s_txbusy_len", tag), busy_cnt, lat - 1 + PAR_ADD);
        end
    endtask

    initial begin
        int bad_tx;
        int bad_busy;
        int done_cnt;
        int rise;
        int fall;

        vecs[0] = '{8'hA5, 1, 10'b1_10100101_0, 1'b0, 161};
        vecs[1] = '{8'h3C, 4, 10'b1_00111100_0, 1'b0, -1};
        vecs[2] = '{8'h07, 1, 10'b1_00000111_0, 1'b1, 161};
        vecs[3] = '{8'h03, 2, 10'b1_00000011_0, 1'b0, -1};
        vecs[4] = '{8'hFF, 3, 10'b1_11111111_0, 1'b0, -1};
        vecs[5] = '{8'h00, 1, 10'b1_00000000_0, 1'b0, 161};

        reset_n = 1'b0;
        txstart = 1'b0;
        din     = '0;
        #12;
        check("reset_tx", int'(tx), 1);
        check("reset_txbusy", int'(txbusy), 0);
        check("reset_txdone", int'(txdone), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // idle with stick tied high
        bad_tx = 0; bad_busy = 0; done_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1)     bad_tx++;
            if (txbusy !== 1'b0) bad_busy++;
            if (txdone !== 1'b0) done_cnt++;
        end
        check("idle_tx_not_high", bad_tx, 0);
        check("idle_txbusy_high", bad_busy, 0);
        check("idle_txdone_pulses", done_cnt, 0);

        for (int v = 0; v < 6; v++) begin
            stick_div = vecs[v].div;
            send(vecs[v].din);
            capture(-1, 8'h00);
            check_frame($sformatf("vec%0d", v), vecs[v].din, vecs[v].div,
                        vecs[v].frame, vecs[v].par, vecs[v].lat);
            @(negedge clk);
            check($sformatf("vec%0d_txdone_width", v), int'(txdone), 0);
            check($sformatf("vec%0d_idle_txbusy", v), int'(txbusy), 0);
            repeat (2) @(negedge clk);
        end

        // bit period at stick every 4th clk: 0x3C has a 4-bit run of ones
        stick_div = 4;
        send(8'h3C);
        capture(-1, 8'h00);
        rise = -1;
        fall = -1;
        for (int j = 1; j < rec_len; j++) begin
            if (rise < 0 && rec_tx[j] == 1'b1 && rec_tx[j-1] == 1'b0) rise = j;
            else if (rise >= 0 && fall < 0 && rec_tx[j] == 1'b0 && rec_tx[j-1] == 1'b1) fall = j;
        end
        check("bit_period_x4", fall - rise, 4 * 64);
        repeat (3) @(negedge clk);

        // txstart during a frame is ignored; txstart in the txdone cycle is accepted
        stick_div = 1;
        send(8'h00);
        capture(50, 8'hFF);
        check_frame("ignored", 8'h00, 1, 10'b1_00000000_0, 1'b0, 161);
        din     = 8'h81;
        txstart = 1'b1;
        @(posedge clk);
        #1;
        txstart = 1'b0;
        din     = 8'h00;
        capture(-1, 8'h00);
        check("b2b_first_sample_tx", int'(rec_tx[0]), 0);
        check_frame("b2b", 8'h81, 1, 10'b1_10000001_0, 1'b0, 161);
        repeat (3) @(negedge clk);

        // asynchronous reset during data bit 3
        send(8'h55);
        repeat (71) @(negedge clk);
        check("pre_reset_tx_bit3", int'(tx), 0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_tx", int'(tx), 1);
        check("async_reset_txbusy", int'(txbusy), 0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (txdone !== 1'b0) done_cnt++;
        end
        check("async_reset_no_txdone", done_cnt, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h5A);
        capture(-1, 8'h00);
        check_frame("post_reset", 8'h5A, 1, 10'b1_01011010_0, 1'b0, 161);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
